// File: rtl/operand_fetch_stage.sv
// Operand fetch between decode and execute: imm/reg operands resolve in 1 cycle, memory operands add their ack wait.
// Accepts only in IDLE with a free output slot; out_* hold while out_valid && !out_ready.
module operand_fetch_stage #(
    parameter int DATA_W   = 16,
    parameter int OPC_W    = 8,
    parameter int REGSEL_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPC_W-1:0]    opcode,
    input  logic [1:0]          mode1,
    input  logic [DATA_W-1:0]   op1,
    input  logic [1:0]          mode2,
    input  logic [DATA_W-1:0]   op2,
    output logic [REGSEL_W-1:0] rf_raddr1,
    input  logic [DATA_W-1:0]   rf_rdata1,
    output logic [REGSEL_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0]   rf_rdata2,
    output logic                mem_req,
    output logic [DATA_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OPC_W-1:0]    out_opcode,
    output logic [DATA_W-1:0]   out_val1,
    output logic [DATA_W-1:0]   out_val2
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH1 = 2'd1,
        S_FETCH2 = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_out_valid;
    logic                r_mem_req;
    logic [DATA_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_addr2;
    logic                r_mem2;
    logic [OPC_W-1:0]    r_out_opcode;
    logic [DATA_W-1:0]   r_out_val1;
    logic [DATA_W-1:0]   r_out_val2;

    logic                w_accept;
    logic                w_ack;
    logic                w_done;
    logic                w_issue2;
    logic [DATA_W-1:0]   w_val1;
    logic [DATA_W-1:0]   w_val2;
    logic [DATA_W-1:0]   w_addr1;
    logic [DATA_W-1:0]   w_addr2;

    assign rf_raddr1  = op1[REGSEL_W-1:0];
    assign rf_raddr2  = op2[REGSEL_W-1:0];
    assign in_ready   = (r_state == S_IDLE) && (!r_out_valid || out_ready) && !flush;
    assign w_accept   = in_valid && in_ready;
    assign w_ack      = r_mem_req && mem_ack;
    // Operand 2's request goes out one cycle after operand 1's ack drops the previous one.
    assign w_issue2   = (r_state == S_FETCH2) && !r_mem_req && !flush;

    assign w_val1  = (mode1 == 2'b00) ? op1 : rf_rdata1;
    assign w_val2  = (mode2 == 2'b00) ? op2 : rf_rdata2;
    assign w_addr1 = (mode1 == 2'b10) ? op1 : rf_rdata1;
    assign w_addr2 = (mode2 == 2'b10) ? op2 : rf_rdata2;

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign out_valid  = r_out_valid;
    assign out_opcode = r_out_opcode;
    assign out_val1   = r_out_val1;
    assign out_val2   = r_out_val2;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (mode1[1])      w_state_nxt = S_FETCH1;
                    else if (mode2[1]) w_state_nxt = S_FETCH2;
                end
            end
            S_FETCH1, S_FETCH2: begin
                if (flush) begin
                    w_state_nxt = (r_mem_req && !w_ack) ? S_DRAIN : S_IDLE;
                end else if (w_ack) begin
                    if (r_state == S_FETCH1 && r_mem2) begin
                        w_state_nxt = S_FETCH2;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done      = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (w_ack) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_addr2      <= '0;
            r_mem2       <= 1'b0;
            r_out_opcode <= '0;
            r_out_val1   <= '0;
            r_out_val2   <= '0;
        end else begin
            if (flush)
                r_out_valid <= 1'b0;
            else if ((w_accept && !mode1[1] && !mode2[1]) || w_done)
                r_out_valid <= 1'b1;
            else if (out_ready)
                r_out_valid <= 1'b0;

            if (w_accept) begin
                r_out_opcode <= opcode;
                r_out_val1   <= w_val1;
                r_out_val2   <= w_val2;
                r_addr2      <= w_addr2;
                r_mem2       <= mode2[1];
                if (mode1[1]) begin
                    r_mem_req  <= 1'b1;
                    r_mem_addr <= w_addr1;
                end else if (mode2[1]) begin
                    r_mem_req  <= 1'b1;
                    r_mem_addr <= w_addr2;
                end
            end

            if (w_ack) begin
                r_mem_req <= 1'b0;
                if (!flush && r_state == S_FETCH1) r_out_val1 <= mem_rdata;
                if (!flush && r_state == S_FETCH2) r_out_val2 <= mem_rdata;
            end

            if (w_issue2) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= r_addr2;
            end
        end
    end

endmodule
